// File: rtl/ioctl_pkg.sv
`default_nettype none
// ============================================================================
// ioctl_pkg : state encoding and shared constants for the ioctl stream player
// Rev 1.0
// ============================================================================
package ioctl_pkg;

  localparam int ADDR_W   = 25;
  localparam int TAIL_LEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_LATCH = 3'd3,
    ST_WRITE = 3'd4,
    ST_GAP   = 3'd5,
    ST_TAIL  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ioctl_player_gap_timer.sv
`default_nettype none
// ============================================================================
// gap_timer : loadable down-counter pacing the idle cycles between writes
// Rev 1.0
// ============================================================================
module gap_timer #(
  parameter int W = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Expire on the final counted cycle so the caller leaves GAP after exactly load_val cycles
  assign expire = (r_cnt <= W'(1));

endmodule
`default_nettype wire

// File: rtl/ioctl_player.sv
`default_nettype none
// ============================================================================
// ioctl_player : replays a source memory image onto the ioctl download bus
// Rev 1.0
// ============================================================================
module ioctl_player
  import ioctl_pkg::*;
#(
  parameter int GAP_W = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        index_in,
  input  logic [24:0]       length,
  input  logic [GAP_W-1:0]  gap,
  output logic              src_rd,
  output logic [24:0]       src_addr,
  input  logic [7:0]        src_data,
  input  logic              ioctl_wait,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              busy,
  output logic              done
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, r_len, r_addr;
  logic [7:0]        r_index, r_dout;
  logic [GAP_W-1:0]  r_gap;
  logic [1:0]        r_tail;
  logic              r_download, r_done;
  logic              w_accept, w_abort, w_last, w_tail_end;
  logic              w_gap_load, w_gap_count, w_gap_expire;

  assign w_accept   = (r_state == ST_IDLE) && start && (length != '0);
  assign w_abort    = (r_state != ST_IDLE) && abort;
  assign w_last     = (r_addr == r_len - ADDR_W'(1));
  assign w_tail_end = (r_tail == 2'(TAIL_LEN - 1));

  gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .load     (w_gap_load),
    .load_val (r_gap),
    .count    (w_gap_count),
    .expire   (w_gap_expire)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_load  = 1'b0;
    w_gap_count = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP: w_state_nxt = ST_FETCH;
      ST_FETCH: if (!ioctl_wait) w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (w_last) begin
          w_state_nxt = ST_TAIL;
        end else if (r_gap == '0) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_GAP;
          w_gap_load  = 1'b1;
        end
      end
      ST_GAP: begin
        w_gap_count = 1'b1;
        if (w_gap_expire) w_state_nxt = ST_FETCH;
      end
      ST_TAIL:  if (w_tail_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_index    <= '0;
      r_dout     <= '0;
      r_gap      <= '0;
      r_tail     <= '0;
      r_download <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              r_index    <= index_in;
              r_len      <= length;
              r_gap      <= gap;
              r_cnt      <= '0;
              r_download <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          r_dout <= src_data;
          r_addr <= r_cnt;
        end
        ST_WRITE: begin
          r_cnt  <= r_cnt + ADDR_W'(1);
          r_tail <= '0;
        end
        ST_TAIL: begin
          r_tail <= r_tail + 2'd1;
          if (w_tail_end) begin
            r_download <= 1'b0;
            r_done     <= !abort;
          end
        end
        default: ;
      endcase
      if (w_abort) r_download <= 1'b0;
    end
  end

  assign busy           = (r_state != ST_IDLE);
  assign src_rd         = (r_state == ST_FETCH) && !ioctl_wait;
  assign src_addr       = r_cnt;
  assign ioctl_wr       = (r_state == ST_WRITE);
  assign ioctl_download = r_download;
  assign ioctl_index    = r_index;
  assign ioctl_addr     = r_addr;
  assign ioctl_dout     = r_dout;
  assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_player.sv
`default_nettype none
// ============================================================================
// tb_ioctl_player : scoreboard bench with a cycle-level reference timeline
// Rev 1.0
// ============================================================================
module tb_ioctl_player;

  localparam int GAP_W = 4;
  localparam int INF   = 32'h7fff_ffff;

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1, start = 1'b0, abort = 1'b0, ioctl_wait = 1'b0;
  logic [7:0]       index_in = '0, src_data = '0;
  logic [24:0]      length = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             src_rd, ioctl_download, ioctl_wr, busy, done;
  logic [24:0]      src_addr, ioctl_addr;
  logic [7:0]       ioctl_index, ioctl_dout;

  ioctl_player #(.GAP_W(GAP_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .abort(abort),
    .index_in(index_in), .length(length), .gap(gap),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data), .ioctl_wait(ioctl_wait),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  // Source image: data appears one cycle after the read strobe, garbage otherwise
  logic [7:0] mem [0:255];
  always @(posedge clk_sys) src_data <= src_rd ? mem[src_addr[7:0]] : 8'($urandom);

  typedef struct {
    int         addr;
    logic [7:0] data;
    int         g;
    bit         last;
  } wr_t;

  wr_t        wrq[$];
  wr_t        e;
  bit         wait_hist [int];
  int         cyc = 0, n_checks = 0, n_errors = 0, wr_seen = 0;
  int         dl_from = 0, dl_to = 0, exp_done = -1, start_cyc = 0, prev_wr = -1, f = 0;
  int         last_addr = 0;
  logic [7:0] cur_idx = '0, last_dout = '0;
  bit         have_prev = 0, mon_en = 0, exp_dl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle status checks plus scoreboard pops on every write strobe
  always @(negedge clk_sys) begin
    wait_hist[cyc] = ioctl_wait;
    if (mon_en) begin
      exp_dl = (cyc >= dl_from) && (cyc < dl_to);
      chk("download", 32'(ioctl_download), 32'(exp_dl));
      chk("busy", 32'(busy), 32'(exp_dl));
      chk("done", 32'(done), 32'(cyc == exp_done));
      if (exp_dl) chk("index", 32'(ioctl_index), 32'(cur_idx));
      if (ioctl_wr) begin
        wr_seen++;
        if (wrq.size() == 0) begin
          chk("unexpected_wr", 32'(ioctl_wr), 32'(0));
        end else begin
          e = wrq.pop_front();
          f = (prev_wr < 0) ? start_cyc + 2 : prev_wr + e.g + 1;
          while (wait_hist.exists(f) && wait_hist[f] && f < cyc) f++;
          chk("wr_time", 32'(cyc), 32'(f + 2));
          chk("wr_addr", 32'(ioctl_addr), 32'(e.addr));
          chk("wr_dout", 32'(ioctl_dout), 32'(e.data));
          prev_wr   = cyc;
          last_addr = e.addr;
          last_dout = e.data;
          have_prev = 1;
          if (e.last) begin
            dl_to    = cyc + 3;
            exp_done = cyc + 3;
          end
        end
      end else if (exp_dl && have_prev) begin
        chk("addr_hold", 32'(ioctl_addr), 32'(last_addr));
        chk("dout_hold", 32'(ioctl_dout), 32'(last_dout));
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_download"}, 32'(ioctl_download), 0);
    chk({tag, "_wr"},       32'(ioctl_wr), 0);
    chk({tag, "_addr"},     32'(ioctl_addr), 0);
    chk({tag, "_dout"},     32'(ioctl_dout), 0);
    chk({tag, "_index"},    32'(ioctl_index), 0);
    chk({tag, "_src_rd"},   32'(src_rd), 0);
    chk({tag, "_src_addr"}, 32'(src_addr), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
  endtask

  task automatic start_xfer(input int len, input int g, input logic [7:0] idx,
                            input bit fixed, input bit with_abort);
    for (int k = 0; k < len && k < 256; k++) mem[k] = fixed ? 8'(8'hA0 + k) : 8'($urandom);
    index_in = idx;
    length   = 25'(len);
    gap      = GAP_W'(g);
    start    = 1'b1;
    abort    = with_abort;
    if (len == 0) begin
      exp_done = cyc + 1;
    end else begin
      start_cyc = cyc;
      dl_from   = cyc + 1;
      dl_to     = INF;
      cur_idx   = idx;
      prev_wr   = -1;
      have_prev = 0;
      for (int k = 0; k < len; k++) wrq.push_back('{addr: k, data: mem[k], g: g, last: (k == len - 1)});
    end
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if (dl_to > cyc + 1) dl_to = cyc + 1;
    if (exp_done > cyc) exp_done = -1;
    wrq.delete();
    tick();
    reset = 1'b0;
    chk_zero("reset");
  endtask

  task automatic wait_end(input int budget, input bit rnd_wait);
    int n = 0;
    while ((wrq.size() != 0 || cyc <= dl_to || cyc <= exp_done) && n < budget) begin
      if (rnd_wait) ioctl_wait = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    ioctl_wait = 1'b0;
    if (n >= budget) begin
      chk("end_timeout", 32'(n), 32'(budget - 1));
      do_reset();
    end
    tick();
    tick();
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_seen < target && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("wr_timeout", 32'(wr_seen), 32'(target));
  endtask

  int base;

  initial begin
    repeat (3) tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    chk_zero("init");

    // Fixed-pattern stream, back-to-back cadence
    start_xfer(4, 0, 8'h11, 1, 0);
    wait_end(300, 0);

    start_xfer(3, 5, 8'h22, 0, 0);
    wait_end(300, 0);

    // Back-pressure held for 10 cycles while the second byte is pending
    base = wr_seen;
    start_xfer(4, 1, 8'h33, 0, 0);
    wait_wr(base + 1);
    ioctl_wait = 1'b1;
    repeat (10) begin
      tick();
      chk("stall_src_rd", 32'(src_rd), 0);
    end
    ioctl_wait = 1'b0;
    wait_end(300, 0);

    start_xfer(0, 3, 8'h44, 0, 0);
    wait_end(50, 0);

    // Abort after the second byte, then a one-byte transfer
    base = wr_seen;
    start_xfer(8, 2, 8'h55, 0, 0);
    wait_wr(base + 2);
    abort    = 1'b1;
    dl_to    = cyc + 1;
    exp_done = -1;
    wrq.delete();
    tick();
    abort = 1'b0;
    wait_end(50, 0);
    start_xfer(1, 0, 8'h66, 0, 0);
    wait_end(100, 0);

    // Starts presented while busy must not restart or queue a transfer
    base = wr_seen;
    start_xfer(6, 2, 8'h77, 0, 0);
    wait_wr(base + 1);
    repeat (6) begin
      index_in = 8'h88;
      length   = 25'($urandom_range(1, 20));
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
    end
    wait_end(300, 0);
    chk("wr_count", 32'(wr_seen - base), 6);

    // Reset in the middle of a gap
    base = wr_seen;
    start_xfer(6, 4, 8'h99, 0, 0);
    wait_wr(base + 2);
    do_reset();
    wait_end(50, 0);

    // Reset beats a simultaneous start
    reset    = 1'b1;
    start    = 1'b1;
    length   = 25'd5;
    index_in = 8'hAA;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_zero("rst_start");
    repeat (4) tick();

    // Start beats a simultaneous abort in IDLE
    start_xfer(3, 1, 8'hBB, 0, 1);
    wait_end(200, 0);

    // Randomized transfers with random back-pressure
    for (int t = 0; t < 12; t++) begin
      start_xfer($urandom_range(1, 12), $urandom_range(0, (1 << GAP_W) - 1),
                 8'($urandom), 0, 0);
      wait_end(2000, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ioctl_player.md
IOCTL_PLAYER -- requirements
Module: ioctl_player

Interface
REQ-001 SHALL have parameter GAP_W, default 4, width of the inter-write gap count.
REQ-002 SHALL have port clk_sys, input, 1, single clock; all state advances on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, terminates an active transfer.
REQ-006 SHALL have port index_in, input, 8, stream index to present on ioctl_index.
REQ-007 SHALL have port length, input, 25, byte count; latched on accepted start.
REQ-008 SHALL have port gap, input, GAP_W, idle cycles after each write; latched on accepted start.
REQ-009 SHALL have port src_rd, output, 1, read strobe to the source image memory.
REQ-010 SHALL have port src_addr, output, 25, source byte address.
REQ-011 SHALL have port src_data, input, 8, source byte, valid exactly 1 cycle after src_rd.
REQ-012 SHALL have port ioctl_wait, input, 1, sink back-pressure; when high, no new fetch starts.
REQ-013 SHALL have ports ioctl_download (1), ioctl_index (8), ioctl_wr (1), ioctl_addr (25), ioctl_dout (8), all outputs, carrying the download stream to the core.
REQ-014 SHALL have ports busy (1) and done (1), outputs, for status and the completion pulse.

Function
REQ-015 SHALL implement states IDLE, SETUP, FETCH, LATCH, WRITE, GAP, TAIL.
REQ-016 In IDLE, start=1 with length!=0 SHALL latch index_in, length and gap, clear the byte counter, and go to SETUP.
REQ-017 In IDLE, start=1 with length==0 SHALL pulse done for 1 cycle, 1 cycle later, and SHALL NOT assert ioctl_download.
REQ-018 ioctl_download and ioctl_index SHALL become valid on entry to SETUP and remain stable until TAIL exits; SETUP SHALL last exactly 1 cycle.
REQ-019 FETCH SHALL wait while ioctl_wait=1; when ioctl_wait=0 it SHALL pulse src_rd for 1 cycle with src_addr equal to the byte counter, then go to LATCH.
REQ-020 LATCH SHALL capture src_data into ioctl_dout and the counter into ioctl_addr, then go to WRITE.
REQ-021 WRITE SHALL assert ioctl_wr for exactly 1 cycle; ioctl_addr and ioctl_dout SHALL be held stable from LATCH until the next LATCH.
REQ-022 After WRITE, the FSM SHALL spend exactly gap cycles in GAP (0 means skip GAP), then go to FETCH.
REQ-023 Without wait, the minimum write cadence SHALL be 3+gap cycles per byte.
REQ-024 After the write with ioctl_addr==length-1, the FSM SHALL go to TAIL instead of GAP.
REQ-025 TAIL SHALL hold ioctl_download=1 for 2 cycles, then deassert it, pulse done for 1 cycle, and return to IDLE.
REQ-026 The byte counter SHALL be 25 bits and increment after each WRITE; length 2^25-1 SHALL complete without wrap.
REQ-027 abort=1 in any non-IDLE state SHALL deassert ioctl_download and ioctl_wr on the next cycle and return to IDLE with no done pulse.
REQ-028 If abort and start are high in the same cycle in IDLE, start SHALL win.
REQ-029 A start during a non-IDLE state SHALL be ignored and SHALL NOT be queued.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 reset SHALL force IDLE, clear the counter, and drive all outputs to 0, mid-transfer included.
REQ-032 After a mid-transfer reset, ioctl_download SHALL be 0 the following cycle, with no done pulse.
REQ-033 If reset and start are high in the same cycle, reset SHALL win.

Structure
REQ-034 The state enumeration and the TAIL_LEN=2 constant SHALL reside in the shared package ioctl_pkg.
REQ-035 The gap timer SHALL be a sub-module named gap_timer, with load, count and expire behaviour.
REQ-036 The implementation SHALL be single-clock, with no latches and no combinational path from inputs to ioctl_* outputs.

Verification
REQ-037 Scenario 1: length=4, gap=0, source bytes A0..A3 -> 4 ioctl_wr pulses 3 cycles apart, addr 0..3, dout A0..A3, then done exactly 3 cycles after the last wr.
REQ-038 Scenario 2: length=3, gap=5 -> wr pulses exactly 8 cycles apart.
REQ-039 Scenario 3: ioctl_wait held high 10 cycles during byte 1 -> src_rd delayed 10 cycles; addr/dout unchanged while stalled; final data intact.
REQ-040 Scenario 4: length=0 start -> done 1 cycle later, ioctl_download never high.
REQ-041 Scenario 5: abort after byte 2 of length=8 -> download low the next cycle, no done, busy 0; a new start with length=1 completes normally.
REQ-042 Scenario 6: reset asserted mid-GAP -> all outputs 0 the next cycle; start during busy ignored, checked by comparing wr count to length.
